// File: rtl/ber_gen_pkg.sv
// rtl/ber_gen_pkg.sv - shared types and frame-size helpers for the BER generator sequencer
package ber_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN_RST,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_VALID_MISMATCH = 2'd1,
    ERR_OVERRUN        = 2'd2,
    ERR_STALL_TIMEOUT  = 2'd3
  } err_code_t;

  function automatic int info_bits(input int rs_k, input int sym_w);
    return rs_k * sym_w;
  endfunction

  function automatic int total_bits(input int rs_n, input int sym_w);
    return rs_n * sym_w;
  endfunction

endpackage

// File: rtl/ber_frame_tracker.sv
// rtl/ber_frame_tracker.sv - mirrors the generator bit schedule, counts frames and checks valid bits per frame
module ber_frame_tracker import ber_gen_pkg::*; #(
  parameter int RS_K            = 60,
  parameter int RS_N            = 68,
  parameter int RS_SYMBOL_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        step,
  input  logic        valid,
  output logic        wrap,
  output logic        mismatch,
  output logic [31:0] frames_done
);

  localparam int INFO_BITS  = info_bits(RS_K, RS_SYMBOL_WIDTH);
  localparam int TOTAL_BITS = total_bits(RS_N, RS_SYMBOL_WIDTH);
  localparam int PW         = $clog2(TOTAL_BITS);

  logic [PW-1:0] pos;
  logic [31:0]   vcnt;
  logic [31:0]   vcnt_next;

  // A valid on the wrap cycle belongs to the frame that is closing.
  always_comb begin
    vcnt_next = vcnt;
    if (valid && vcnt != '1) vcnt_next = vcnt + 32'd1;
  end

  assign wrap     = step && (pos == PW'(TOTAL_BITS - 1));
  assign mismatch = wrap && (vcnt_next != 32'(INFO_BITS));

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      pos         <= '0;
      vcnt        <= '0;
      frames_done <= '0;
    end else begin
      if (step) pos <= wrap ? '0 : pos + PW'(1);
      vcnt <= wrap ? '0 : vcnt_next;
      if (wrap && frames_done != '1) frames_done <= frames_done + 32'd1;
    end
  end

endmodule

// File: rtl/ber_gen_sequencer.sv
// rtl/ber_gen_sequencer.sv - run controller for the RS frame data generators
module ber_gen_sequencer import ber_gen_pkg::*; #(
  parameter int RS_K            = 60,
  parameter int RS_N            = 68,
  parameter int RS_SYMBOL_WIDTH = 8,
  parameter int RST_CYCLES      = 2,
  parameter int STALL_LIMIT     = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] n_frames,
  input  logic        sink_ready,
  input  logic        gen_valid,
  output logic        gen_rstn,
  output logic        gen_en,
  output logic [31:0] gen_n_pcs,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [1:0]  err_code,
  output logic [31:0] frames_done,
  output logic [31:0] bits_seen
);

  state_t      state;
  err_code_t   err_q;
  logic [31:0] n_frames_q;
  logic [31:0] rst_cnt;
  logic [31:0] stall_cnt;
  logic        drain_cnt;
  logic        trk_clear, trk_step, trk_valid;
  logic        wrap, mismatch, last_wrap, count_valid;

  assign gen_en      = (state == ST_RUN) && sink_ready && !abort;
  assign gen_n_pcs   = n_frames_q;
  assign err_code    = err_q;
  assign trk_clear   = (state == ST_IDLE) && start;
  // Stepping ignores abort so an abort on the final wrap still counts that frame.
  assign trk_step    = (state == ST_RUN) && sink_ready;
  assign trk_valid   = (state == ST_RUN) && gen_valid;
  assign count_valid = ((state == ST_RUN) || (state == ST_DRAIN)) && gen_valid;
  assign last_wrap   = wrap && (({1'b0, frames_done} + 33'd1) == {1'b0, n_frames_q});

  ber_frame_tracker #(
    .RS_K            (RS_K),
    .RS_N            (RS_N),
    .RS_SYMBOL_WIDTH (RS_SYMBOL_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (trk_clear),
    .step        (trk_step),
    .valid       (trk_valid),
    .wrap        (wrap),
    .mismatch    (mismatch),
    .frames_done (frames_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      err_q      <= ERR_NONE;
      n_frames_q <= '0;
      rst_cnt    <= '0;
      stall_cnt  <= '0;
      drain_cnt  <= 1'b0;
      gen_rstn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      bits_seen  <= '0;
    end else begin
      done     <= 1'b0;
      gen_rstn <= 1'b1;
      if (count_valid && bits_seen != '1) bits_seen <= bits_seen + 32'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            n_frames_q <= n_frames;
            aborted    <= 1'b0;
            err_q      <= ERR_NONE;
            bits_seen  <= '0;
            stall_cnt  <= '0;
            rst_cnt    <= '0;
            busy       <= 1'b1;
            if (n_frames != '0) begin
              state    <= ST_GEN_RST;
              gen_rstn <= 1'b0;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end

        ST_GEN_RST: begin
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= ST_FIN;
          end else if (rst_cnt == 32'(RST_CYCLES - 1)) begin
            state <= ST_RUN;
          end else begin
            rst_cnt  <= rst_cnt + 32'd1;
            gen_rstn <= 1'b0;
          end
        end

        ST_RUN: begin
          if (mismatch && err_q == ERR_NONE) err_q <= ERR_VALID_MISMATCH;
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= ST_FIN;
          end else if (last_wrap) begin
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else if (sink_ready) begin
            stall_cnt <= '0;
          end else begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (STALL_LIMIT != 0 && stall_cnt == 32'(STALL_LIMIT - 1)) begin
              if (err_q == ERR_NONE) err_q <= ERR_STALL_TIMEOUT;
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end

        ST_DRAIN: begin
          if (gen_valid && err_q == ERR_NONE) err_q <= ERR_OVERRUN;
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= ST_FIN;
          end else if (drain_cnt) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
